// File: rtl/uart_pkg.sv
// Shared UART types and constants for the rx/tx cores.
// Holds the receive FSM state type, frame width and default bit timing.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } rx_state_t;

  localparam int DATA_BITS = 8;
  localparam int CLKS_PER_BIT_DEF = 16;

endpackage

// File: rtl/uart_sync.sv
// Two-flop synchronizer for asynchronous inputs (rx, cts).
// Ports: clk, rst_n (async low), rst_val (reset level), d (async in), q (synced out).
module uart_sync #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] rst_val,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] meta_d, meta_q;
  logic [WIDTH-1:0] sync_d, sync_q;

  always_comb begin
    meta_d = d;
    sync_d = meta_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= rst_val;
      sync_q <= rst_val;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign q = sync_q;

endmodule

// File: rtl/rx_core.sv
// UART 8N1 receive core: oversampling, 3-sample majority, valid/ready buffer.
// Ports: rx_clk, reset_n, rx, rx_ready in; rx_valid, rx_data, rx_done, frame_err, overrun out.
module rx_core
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
  input  logic                 rx_clk,
  input  logic                 reset_n,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic                 rx_valid,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 overrun
);

  localparam int MID = CLKS_PER_BIT / 2;
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int BW = $clog2(DATA_BITS);

  localparam logic [CW-1:0] S_PRE = CW'(MID - 1);
  localparam logic [CW-1:0] S_MID = CW'(MID);
  localparam logic [CW-1:0] S_DEC = CW'(MID + 1);
  localparam logic [CW-1:0] S_END = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] S_ONE = CW'(1);
  localparam logic [BW-1:0] B_END = BW'(DATA_BITS - 1);

  if (CLKS_PER_BIT < 4) begin : g_chk
    $error("rx_core: CLKS_PER_BIT must be >= 4");
  end

  logic rx_s;

  uart_sync #(.WIDTH(1)) u_sync (
    .clk     (rx_clk),
    .rst_n   (reset_n),
    .rst_val (1'b1),
    .d       (rx),
    .q       (rx_s)
  );

  rx_state_t            state_d, state_q;
  logic [CW-1:0]        scnt_d, scnt_q;
  logic [BW-1:0]        bcnt_d, bcnt_q;
  logic [1:0]           smp_d, smp_q;
  logic [DATA_BITS-1:0] shift_d, shift_q;
  logic                 prev_d, prev_q;
  logic                 valid_d, valid_q;
  logic [DATA_BITS-1:0] data_d, data_q;
  logic                 done_d, done_q;
  logic                 ferr_d, ferr_q;
  logic                 ovr_d, ovr_q;

  logic          maj;
  logic          at_dec;
  logic          at_end;
  logic [CW-1:0] scnt_nx;

  always_comb begin
    maj = (smp_q[0] & smp_q[1])
        | (smp_q[0] & rx_s)
        | (smp_q[1] & rx_s);
    at_dec  = (scnt_q == S_DEC);
    at_end  = (scnt_q == S_END);
    scnt_nx = at_end ? '0 : scnt_q + 1'b1;

    state_d = state_q;
    scnt_d  = scnt_q;
    bcnt_d  = bcnt_q;
    smp_d   = smp_q;
    shift_d = shift_q;
    prev_d  = rx_s;
    valid_d = valid_q;
    data_d  = data_q;
    done_d  = 1'b0;
    ferr_d  = 1'b0;
    ovr_d   = 1'b0;

    if (valid_q && rx_ready) valid_d = 1'b0;

    if (scnt_q == S_PRE) smp_d[0] = rx_s;
    if (scnt_q == S_MID) smp_d[1] = rx_s;

    unique case (state_q)
      IDLE: begin
        scnt_d = '0;
        // The edge cycle itself is sample 0 of the start bit.
        if (!rx_s && prev_q) begin
          state_d = START;
          scnt_d  = S_ONE;
        end
      end
      START: begin
        scnt_d = scnt_nx;
        if (at_dec && maj) begin
          state_d = IDLE;
          scnt_d  = '0;
        end else if (at_end) begin
          state_d = DATA;
          bcnt_d  = '0;
        end
      end
      DATA: begin
        scnt_d = scnt_nx;
        if (at_dec) shift_d[bcnt_q] = maj;
        if (at_end) begin
          if (bcnt_q == B_END) state_d = STOP;
          else bcnt_d = bcnt_q + 1'b1;
        end
      end
      STOP: begin
        scnt_d = scnt_nx;
        // Leave at the centre so a new start edge can land late in the stop bit.
        if (at_dec) begin
          state_d = IDLE;
          scnt_d  = '0;
          done_d  = 1'b1;
          if (!maj) begin
            ferr_d = 1'b1;
          end else if (!valid_q || rx_ready) begin
            data_d  = shift_q;
            valid_d = 1'b1;
          end else begin
            ovr_d = 1'b1;
          end
        end
      end
      default: begin
        state_d = IDLE;
        scnt_d  = '0;
      end
    endcase
  end

  always_ff @(posedge rx_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      scnt_q  <= '0;
      bcnt_q  <= '0;
      smp_q   <= 2'b11;
      shift_q <= '0;
      prev_q  <= 1'b1;
      valid_q <= 1'b0;
      data_q  <= '0;
      done_q  <= 1'b0;
      ferr_q  <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      scnt_q  <= scnt_d;
      bcnt_q  <= bcnt_d;
      smp_q   <= smp_d;
      shift_q <= shift_d;
      prev_q  <= prev_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      done_q  <= done_d;
      ferr_q  <= ferr_d;
      ovr_q   <= ovr_d;
    end
  end

  assign rx_valid  = valid_q;
  assign rx_data   = data_q;
  assign rx_done   = done_q;
  assign frame_err = ferr_q;
  assign overrun   = ovr_q;

endmodule

// File: tb/tb_rx_core.sv
// Directed bench for rx_core: frames, glitches, errors, overrun, reset.
// Checks with immediate assertions; prints one TB_RESULT summary line.
module tb_rx_core;

  logic       rx_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       rx = 1'b1;
  logic       rx_ready = 1'b1;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic       rx_done;
  logic       frame_err;
  logic       overrun;

  rx_core #(.CLKS_PER_BIT(16)) dut (
    .rx_clk    (rx_clk),
    .reset_n   (reset_n),
    .rx        (rx),
    .rx_ready  (rx_ready),
    .rx_valid  (rx_valid),
    .rx_data   (rx_data),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .overrun   (overrun)
  );

  always #5 rx_clk = ~rx_clk;

  int checks = 0;
  int failures = 0;

  int cyc = 0;
  int n_done = 0, n_ferr = 0, n_ovr = 0, n_rise = 0;
  int n_wide = 0, n_excl = 0, n_unst = 0;
  int rise_cyc = 0;
  logic [7:0] got[$];
  logic vprev = 0, rprev = 0, dnprev = 0, feprev = 0, ovprev = 0;
  logic [7:0] dprev = 0;

  always @(posedge rx_clk) cyc++;

  // Sample one time unit before each rising edge.
  always @(negedge rx_clk) begin
    #4;
    if (rx_done) n_done++;
    if (frame_err) n_ferr++;
    if (overrun) n_ovr++;
    if (frame_err && overrun) n_excl++;
    if ((rx_done && dnprev) || (frame_err && feprev) || (overrun && ovprev))
      n_wide++;
    if (rx_valid && !vprev) begin
      n_rise++;
      rise_cyc = cyc;
    end
    if (vprev && !rprev && rx_valid && rx_data !== dprev) n_unst++;
    if (rx_valid && rx_ready) got.push_back(rx_data);
    vprev  = rx_valid;
    rprev  = rx_ready;
    dprev  = rx_data;
    dnprev = rx_done;
    feprev = frame_err;
    ovprev = overrun;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] got_at(input int k);
    if (k < got.size()) return {24'd0, got[k]};
    return 32'hDEAD;
  endfunction

  task automatic idle(input int n);
    repeat (n) @(negedge rx_clk);
  endtask

  task automatic send(input logic [7:0] d, input int stop_len,
                      input logic stop_v, input int flip_bit);
    rx = 1'b0;
    idle(16);
    for (int b = 0; b < 8; b++) begin
      rx = d[b];
      if (b == flip_bit) begin
        idle(8);
        rx = ~d[b];
        idle(1);
        rx = d[b];
        idle(7);
      end else begin
        idle(16);
      end
    end
    rx = stop_v;
    idle(stop_len);
  endtask

  int t0;
  int e_done = 0, e_got = 0;
  logic [7:0] exp_q[$];

  initial begin
    idle(3);
    chk("rst_valid", rx_valid, 0);
    chk("rst_data", rx_data, 0);
    chk("rst_done", rx_done, 0);
    chk("rst_ferr", frame_err, 0);
    chk("rst_ovr", overrun, 0);
    reset_n = 1'b1;
    idle(5);

    // 1: single frame, latency
    t0 = cyc;
    send(8'hA5, 16, 1'b1, -1);
    idle(10);
    e_done++; e_got++;
    chk("t1_latency", rise_cyc - t0, 156);
    chk("t1_count", got.size(), e_got);
    chk("t1_data", got_at(0), 8'hA5);
    chk("t1_done", n_done, e_done);
    chk("t1_ferr", n_ferr, 0);
    chk("t1_ovr", n_ovr, 0);

    // 2: 100 back-to-back frames, short stop bit
    for (int i = 0; i < 100; i++) begin
      exp_q.push_back(8'($urandom_range(0, 255)));
      send(exp_q[i], 10, 1'b1, -1);
    end
    rx = 1'b1;
    idle(20);
    e_done += 100;
    for (int i = 0; i < 100; i++)
      chk($sformatf("t2_byte%0d", i), got_at(e_got + i), exp_q[i]);
    e_got += 100;
    chk("t2_count", got.size(), e_got);
    chk("t2_done", n_done, e_done);
    chk("t2_ferr", n_ferr, 0);
    chk("t2_ovr", n_ovr, 0);

    // 3: short low glitch
    rx = 1'b0;
    idle(3);
    rx = 1'b1;
    idle(40);
    chk("t3_done", n_done, e_done);
    chk("t3_rise", n_rise, 101);
    chk("t3_count", got.size(), e_got);
    chk("t3_valid", rx_valid, 0);

    // 4: framing error, then recovery
    send(8'h3C, 16, 1'b0, -1);
    e_done++;
    chk("t4_ferr", n_ferr, 1);
    chk("t4_done", n_done, e_done);
    chk("t4_valid", rx_valid, 0);
    rx = 1'b1;
    idle(20);
    send(8'h81, 16, 1'b1, -1);
    idle(10);
    e_done++; e_got++;
    chk("t4_count", got.size(), e_got);
    chk("t4_data", got_at(e_got - 1), 8'h81);

    // 5: overrun with stalled consumer
    rx_ready = 1'b0;
    send(8'h11, 16, 1'b1, -1);
    send(8'h22, 16, 1'b1, -1);
    idle(10);
    e_done += 2;
    chk("t5_valid", rx_valid, 1);
    chk("t5_data", rx_data, 8'h11);
    chk("t5_ovr", n_ovr, 1);
    chk("t5_ferr", n_ferr, 1);
    chk("t5_done", n_done, e_done);
    rx_ready = 1'b1;
    idle(3);
    e_got++;
    chk("t5_consumed", rx_valid, 0);
    chk("t5_count", got.size(), e_got);
    chk("t5_got", got_at(e_got - 1), 8'h11);

    // 6: reset mid-frame drops buffer and frame
    rx_ready = 1'b0;
    send(8'h5A, 16, 1'b1, -1);
    idle(5);
    e_done++;
    chk("t6_buf", rx_valid, 1);
    rx = 1'b0;
    idle(16);
    for (int b = 0; b < 4; b++) begin
      rx = 1'b1;
      idle(16);
    end
    idle(8);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_valid", rx_valid, 0);
    chk("t6_rst_data", rx_data, 0);
    chk("t6_rst_done", rx_done, 0);
    idle(3);
    reset_n = 1'b1;
    rx_ready = 1'b1;
    idle(5);
    send(8'h00, 16, 1'b1, -1);
    idle(10);
    e_done++; e_got++;
    chk("t6_count", got.size(), e_got);
    chk("t6_data", got_at(e_got - 1), 8'h00);

    // 6b: single-cycle flip at the bit centre
    send(8'h6B, 16, 1'b1, 2);
    idle(10);
    e_done++; e_got++;
    chk("t6_flip_count", got.size(), e_got);
    chk("t6_flip_data", got_at(e_got - 1), 8'h6B);
    chk("t6_done", n_done, e_done);

    chk("pulse_width", n_wide, 0);
    chk("pulse_excl", n_excl, 0);
    chk("data_stable", n_unst, 0);
    chk("ferr_total", n_ferr, 1);
    chk("ovr_total", n_ovr, 1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
